// File: rtl/dac_output_conditioner_pkg.sv
// Shared definitions for the DAC output conditioner.
// Holds the config register map, the CTRL bit positions and the reset
// defaults used by the top-level register file and the per-channel slew logic.
package dac_output_conditioner_pkg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 3;

    // Config register map (4-bit address space, 7 registers used)
    typedef enum logic [3:0] {
        ADDR_CH0_MIN  = 4'd0,
        ADDR_CH0_MAX  = 4'd1,
        ADDR_CH0_STEP = 4'd2,
        ADDR_CH1_MIN  = 4'd3,
        ADDR_CH1_MAX  = 4'd4,
        ADDR_CH1_STEP = 4'd5,
        ADDR_CTRL     = 4'd6
    } cfg_addr_e;

    // CTRL bit positions
    localparam int CTRL_EN0_BIT  = 0;
    localparam int CTRL_EN1_BIT  = 1;
    localparam int CTRL_HOLD_BIT = 2;

    // Reset defaults: full-scale window, unlimited step, both channels off
    localparam logic [DATA_W-1:0] RST_MIN    = 16'h8000;
    localparam logic [DATA_W-1:0] RST_MAX    = 16'h7FFF;
    localparam logic [DATA_W-1:0] RST_STEP   = 16'h0000;
    localparam logic [DATA_W-1:0] RST_TARGET = 16'h0000;
    localparam logic [DATA_W-1:0] RST_DAC    = 16'h0000;
    localparam logic [CTRL_W-1:0] RST_CTRL   = 3'b000;

endpackage

// File: rtl/dac_slew_channel.sv
// One conditioned DAC channel: stores the requested target, clamps it to the
// configured window, and slews the registered output toward it by at most
// STEP per cycle.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   valid, sample    latch a new signed target (stored unclamped)
//   min_val, max_val signed clamp window; MIN wins when MIN > MAX
//   step             unsigned slew limit, 0 = jump directly
//   en, hold         channel enable (off ramps to 0), freeze output
//   dac              registered signed output
//   settled, railed  registered flags: output at effective target / target clipped
module dac_slew_channel
    import dac_output_conditioner_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] sample,
    input  logic [W-1:0] min_val,
    input  logic [W-1:0] max_val,
    input  logic [W-1:0] step,
    input  logic         en,
    input  logic         hold,
    output logic [W-1:0] dac,
    output logic         settled,
    output logic         railed
);

    logic signed [W-1:0] target_r;
    logic        [W-1:0] dac_r;
    logic                settled_r;
    logic                railed_r;

    logic signed [W-1:0] lo_s;
    logic signed [W-1:0] hi_s;
    logic signed [W-1:0] eff_s;
    logic                outside_s;
    logic signed [W:0]   diff_s;
    logic        [W:0]   mag_s;
    logic        [W-1:0] slew_s;
    logic        [W-1:0] next_dac_s;

    // Effective target (clamp) and the next slewed output value
    always_comb begin
        lo_s      = min_val;
        hi_s      = max_val;
        outside_s = (target_r < lo_s) || (target_r > hi_s);

        if (!en) begin
            eff_s = '0;
        end else if (lo_s > hi_s) begin
            eff_s = lo_s;
        end else if (target_r < lo_s) begin
            eff_s = lo_s;
        end else if (target_r > hi_s) begin
            eff_s = hi_s;
        end else begin
            eff_s = target_r;
        end

        // One extra bit so full-scale swings (-32768 <-> 32767) cannot wrap
        diff_s = {eff_s[W-1], eff_s} - {dac_r[W-1], dac_r};
        mag_s  = diff_s[W] ? ((~diff_s) + {{W{1'b0}}, 1'b1}) : diff_s;

        // Partial steps always land between dac_r and eff_s, so W bits suffice
        if ((step == '0) || (mag_s <= {1'b0, step})) begin
            slew_s = eff_s;
        end else if (diff_s[W]) begin
            slew_s = dac_r - step;
        end else begin
            slew_s = dac_r + step;
        end

        if (hold) begin
            next_dac_s = dac_r;
        end else begin
            next_dac_s = slew_s;
        end
    end

    // Target latch, output register and its flags
    always_ff @(posedge clk) begin
        if (rst) begin
            target_r  <= W'(RST_TARGET);
            dac_r     <= W'(RST_DAC);
            settled_r <= 1'b1;
            railed_r  <= 1'b0;
        end else begin
            if (valid) begin
                target_r <= sample;
            end
            dac_r     <= next_dac_s;
            settled_r <= (next_dac_s == eff_s);
            railed_r  <= en && outside_s;
        end
    end

    assign dac     = dac_r;
    assign settled = settled_r;
    assign railed  = railed_r;

endmodule

// File: rtl/dac_output_conditioner.sv
// DAC output conditioner top: config register file, registered readback and
// two slew-limited channels feeding the AD9783 driver.
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   cfg_we_in/addr_in/data_in      one-cycle config write
//   cfg_data_out                   registered readback of cfg_addr_in
//   valid_in, ch0_in, ch1_in       requested signed samples
//   DAC0_out, DAC1_out             conditioned signed samples
//   settled_out, railed_out        per-channel status flags
module dac_output_conditioner
    import dac_output_conditioner_pkg::*;
#(
    parameter int W   = DATA_W,
    parameter int NCH = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           cfg_we_in,
    input  logic [3:0]     cfg_addr_in,
    input  logic [W-1:0]   cfg_data_in,
    output logic [W-1:0]   cfg_data_out,
    input  logic           valid_in,
    input  logic [W-1:0]   ch0_in,
    input  logic [W-1:0]   ch1_in,
    output logic [W-1:0]   DAC0_out,
    output logic [W-1:0]   DAC1_out,
    output logic [NCH-1:0] settled_out,
    output logic [NCH-1:0] railed_out
);

    logic [W-1:0]      ch0_min_r;
    logic [W-1:0]      ch0_max_r;
    logic [W-1:0]      ch0_step_r;
    logic [W-1:0]      ch1_min_r;
    logic [W-1:0]      ch1_max_r;
    logic [W-1:0]      ch1_step_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [W-1:0]      rd_data_s;
    logic [W-1:0]      cfg_data_r;

    // Config register file; unmapped addresses drop the write
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ch0_min_r  <= W'(RST_MIN);
            ch0_max_r  <= W'(RST_MAX);
            ch0_step_r <= W'(RST_STEP);
            ch1_min_r  <= W'(RST_MIN);
            ch1_max_r  <= W'(RST_MAX);
            ch1_step_r <= W'(RST_STEP);
            ctrl_r     <= RST_CTRL;
        end else if (cfg_we_in) begin
            case (cfg_addr_in)
                ADDR_CH0_MIN:  ch0_min_r  <= cfg_data_in;
                ADDR_CH0_MAX:  ch0_max_r  <= cfg_data_in;
                ADDR_CH0_STEP: ch0_step_r <= cfg_data_in;
                ADDR_CH1_MIN:  ch1_min_r  <= cfg_data_in;
                ADDR_CH1_MAX:  ch1_max_r  <= cfg_data_in;
                ADDR_CH1_STEP: ch1_step_r <= cfg_data_in;
                ADDR_CTRL:     ctrl_r     <= cfg_data_in[CTRL_W-1:0];
                default:       ctrl_r     <= ctrl_r;
            endcase
        end
    end

    // Readback mux; unmapped addresses read as zero
    always_comb begin
        rd_data_s = '0;
        case (cfg_addr_in)
            ADDR_CH0_MIN:  rd_data_s = ch0_min_r;
            ADDR_CH0_MAX:  rd_data_s = ch0_max_r;
            ADDR_CH0_STEP: rd_data_s = ch0_step_r;
            ADDR_CH1_MIN:  rd_data_s = ch1_min_r;
            ADDR_CH1_MAX:  rd_data_s = ch1_max_r;
            ADDR_CH1_STEP: rd_data_s = ch1_step_r;
            ADDR_CTRL:     rd_data_s = {{(W-CTRL_W){1'b0}}, ctrl_r};
            default:       rd_data_s = '0;
        endcase
    end

    // Registered readback
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cfg_data_r <= '0;
        end else begin
            cfg_data_r <= rd_data_s;
        end
    end

    assign cfg_data_out = cfg_data_r;

    dac_slew_channel #(.W(W)) u_ch0 (
        .clk     (clk_in),
        .rst     (rst_in),
        .valid   (valid_in),
        .sample  (ch0_in),
        .min_val (ch0_min_r),
        .max_val (ch0_max_r),
        .step    (ch0_step_r),
        .en      (ctrl_r[CTRL_EN0_BIT]),
        .hold    (ctrl_r[CTRL_HOLD_BIT]),
        .dac     (DAC0_out),
        .settled (settled_out[0]),
        .railed  (railed_out[0])
    );

    dac_slew_channel #(.W(W)) u_ch1 (
        .clk     (clk_in),
        .rst     (rst_in),
        .valid   (valid_in),
        .sample  (ch1_in),
        .min_val (ch1_min_r),
        .max_val (ch1_max_r),
        .step    (ch1_step_r),
        .en      (ctrl_r[CTRL_EN1_BIT]),
        .hold    (ctrl_r[CTRL_HOLD_BIT]),
        .dac     (DAC1_out),
        .settled (settled_out[1]),
        .railed  (railed_out[1])
    );

endmodule

// File: doc/dac_output_conditioner.md
DAC_OUTPUT_CONDITIONER -- requirements
Module: dac_output_conditioner

Interface
REQ-001 Parameter: W, default 16, width of the DAC sample and config data paths.
REQ-002 Parameter: NCH, default 2, fixed at 2 (channel 0 and channel 1).
REQ-003 Port: clk_in  input  1  the single system clock; all logic is on its rising edge.
REQ-004 Port: rst_in  input  1  reset, synchronous and active-high.
REQ-005 Port: cfg_we_in  input  1  config write strobe, one cycle.
REQ-006 Port: cfg_addr_in  input  4  config register address.
REQ-007 Port: cfg_data_in  input  16  config write data.
REQ-008 Port: cfg_data_out  output  16  registered readback of the register at cfg_addr_in.
REQ-009 Port: valid_in  input  1  qualifies the sample inputs.
REQ-010 Port: ch0_in, ch1_in  input  16 each  signed two's-complement requested samples.
REQ-011 Port: DAC0_out, DAC1_out  output  16 each  signed conditioned samples for the AD9783 driver DAC0_in/DAC1_in.
REQ-012 Port: settled_out  output  2  per channel, the output equals its effective target.
REQ-013 Port: railed_out  output  2  per channel, the latched target was clipped by min/max.

Function
REQ-014 Config map: 0 CH0_MIN, 1 CH0_MAX, 2 CH0_STEP, 3 CH1_MIN, 4 CH1_MAX, 5 CH1_STEP, 6 CTRL (bit0 EN0, bit1 EN1, bit2 HOLD).
REQ-015 Unused addresses shall ignore writes and read back 0.
REQ-016 A cfg write shall take effect on the next cycle; cfg_data_out shall be valid one cycle after the address is presented.
REQ-017 On valid_in, ch0_in and ch1_in shall be stored unclamped in per-channel target registers.
REQ-018 Effective target = 0 when ENx=0; otherwise clamp(target, MIN, MAX), evaluated every cycle with the current config.
REQ-019 If MIN > MAX, the effective target shall be MIN.
REQ-020 Each cycle with HOLD=0, the output shall move toward the effective target by min(|diff|, STEP); STEP=0 means an unlimited, direct step.
REQ-021 STEP shall be treated as unsigned, and diff shall be computed in 17-bit signed arithmetic so that no wrap occurs between -32768 and 32767.
REQ-022 With HOLD=1, outputs shall be frozen; targets shall still latch, and output movement shall resume when HOLD clears.
REQ-023 Latency: valid_in at cycle N shall latch the target at the N+1 edge; the first output step shall be visible after the N+2 edge.
REQ-024 settled_out[x] shall be registered alongside the output, high when the new output equals the effective target.
REQ-025 railed_out[x] shall be high while the stored target lies outside [MIN, MAX] and ENx=1.
REQ-026 valid_in asserted during a ramp shall retarget immediately, stepping from the current output with no restart.
REQ-027 A cfg write and valid_in in the same cycle shall both be accepted; the clamp on the next cycle shall use the new config.
REQ-028 Clearing ENx shall ramp channel x toward 0 at STEP, never jumping.

Reset
REQ-029 rst_in shall set the following: DAC0_out and DAC1_out = 0; targets = 0; MIN = 16'h8000; MAX = 16'h7FFF; STEP = 0; CTRL = 0.
REQ-030 rst_in shall also set settled_out = 2'b11, railed_out = 0 and cfg_data_out = 0.
REQ-031 Reset asserted mid-ramp shall force all reset values on the next edge; ramping shall not continue after reset.

Structure
REQ-032 A shared package/include shall hold the register addresses, the CTRL bit positions and the reset defaults.
REQ-033 One sub-module, dac_slew_channel, shall implement the target register, clamp, slew step and flags; it shall be instantiated twice.
REQ-034 The top level shall contain only the config register file, readback mux and instances.

Verification
REQ-035 Bench scenario (default reset config): EN0=1, STEP=0, ch0_in=16'h1234 on valid_in -> DAC0_out=16'h1234 exactly 2 cycles later, with settled_out[0]=1.
REQ-036 Bench scenario (slew): STEP0=100, target 1000 from 0 -> DAC0_out = 100, 200, ..., 1000 over 10 cycles; settled_out[0] shall rise on the 1000 cycle.
REQ-037 Bench scenario (clamp): MAX0=500, ch0_in=700 -> DAC0_out=500 and railed_out[0]=1; then MAX0=800 -> DAC0_out=700 and railed_out[0]=0.
REQ-038 Bench scenario (extremes): STEP=0, target 16'h7FFF, then 16'h8000 -> the output shall flip in one step with no overflow; with STEP=16'hFFFF the behaviour shall be identical.
REQ-039 Bench scenario (HOLD): HOLD=1 mid-ramp at 300 toward 1000 -> the output shall stay at 300; HOLD=0 -> the ramp shall resume at 400.
REQ-040 Bench scenario (reset): rst_in pulsed mid-ramp at 300 -> all outputs and registers shall equal the REQ-029/REQ-030 reset values on the next edge.
